// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends a multi-character UART frame, most-significant character first.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 1764,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [NUM_BYTES*DATA_BITS-1:0]     in_data,
  output logic                               bit_out,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt
);
  localparam int BW       = $clog2(NUM_BYTES+1);
  localparam int STOP_LEN = STOP_BITS*CLKS_PER_BIT;
  localparam int GAP_LEN  = GAP_CLKS > 0 ? GAP_CLKS : 1;
  localparam int CMAX     = STOP_LEN > GAP_LEN ? STOP_LEN : GAP_LEN;
  localparam int CW       = $clog2(CMAX);
  localparam int IW       = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, ch;
  logic                 par_q, par_d;
  logic                 bit_out_q, bit_out_d, busy_q, busy_d, done_q, done_d;
  logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
  logic                 last, load;
  int                   ld_sel;

  assign bit_out  = bit_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_cnt = byte_cnt_q;

  // Character to load: 0 on acceptance, next one after STOP, current count after GAP
  always_comb begin
    ld_sel = state_q == STOP ? int'(byte_cnt_q) + 1 : (state_q == GAP ? int'(byte_cnt_q) : 0);
    ch     = DATA_BITS'(in_data >> (DATA_BITS*(NUM_BYTES-1-ld_sel)));
    last   = state_q == STOP ? cnt_q == CW'(STOP_LEN-1) :
             state_q == GAP  ? cnt_q == CW'(GAP_LEN-1)  : cnt_q == CW'(CLKS_PER_BIT-1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = last ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    sh_d       = sh_q;
    par_d      = par_q;
    bit_out_d  = bit_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          load       = 1'b1;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
        end
      end
      START: if (last) begin
        state_d   = DATA;
        bit_out_d = sh_q[0];
        idx_d     = '0;
      end
      DATA: if (last) begin
        if (idx_q == IW'(DATA_BITS-1)) begin
          state_d   = PARITY_MODE != 0 ? PARITY : STOP;
          bit_out_d = PARITY_MODE != 0 ? par_q : 1'b1;
        end else begin
          idx_d     = idx_q + IW'(1);
          sh_d      = sh_q >> 1;
          bit_out_d = sh_q[1];
        end
      end
      PARITY: if (last) begin
        state_d   = STOP;
        bit_out_d = 1'b1;
      end
      STOP: if (last) begin
        byte_cnt_d = byte_cnt_q + BW'(1);
        if (byte_cnt_q == BW'(NUM_BYTES-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (GAP_CLKS > 0) state_d = GAP;
        else load = 1'b1;
      end
      GAP: if (last) load = 1'b1;
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d   = START;
      bit_out_d = 1'b0;
      sh_d      = ch;
      par_d     = (^ch) ^ (PARITY_MODE == 2);
      cnt_d     = '0;
    end
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      bit_out_d  = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      byte_cnt_d = byte_cnt_q;
      cnt_d      = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      bit_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      bit_out_q  <= bit_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed checks of line timing, parity, gap, abort and reset.
module tb_uart_frame_tx;
  logic        clk, rst_n;
  logic [15:0] in_data;
  logic        st [4];
  logic        ab [4];
  logic        bo [4];
  logic        bsy [4];
  logic        dn [4];
  logic [1:0]  bc [4];
  int          n_cmp, n_bad;
  bit          exp_q [$];
  logic [0:19] l028;

  uart_frame_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(2), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .GAP_CLKS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .in_data(in_data),
    .bit_out(bo[0]), .busy(bsy[0]), .done(dn[0]), .byte_cnt(bc[0]));
  uart_frame_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(2), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .GAP_CLKS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .in_data(in_data),
    .bit_out(bo[1]), .busy(bsy[1]), .done(dn[1]), .byte_cnt(bc[1]));
  uart_frame_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(2), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .GAP_CLKS(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]), .in_data(in_data),
    .bit_out(bo[2]), .busy(bsy[2]), .done(dn[2]), .byte_cnt(bc[2]));
  uart_frame_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(2), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .GAP_CLKS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .abort(ab[3]), .in_data(in_data),
    .bit_out(bo[3]), .busy(bsy[3]), .done(dn[3]), .byte_cnt(bc[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic load_hand(input logic [0:19] v);
    exp_q.delete();
    for (int i = 0; i < 20; i++) push(v[i], 4);
  endtask

  // Per-clock line expansion of a two-character frame at 4 clocks per bit
  task automatic build(input logic [15:0] d, input int pm, input int sb, input int gap);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      b = k == 0 ? d[15:8] : d[7:0];
      push(1'b0, 4);
      for (int i = 0; i < 8; i++) push(b[i], 4);
      if (pm != 0) push((^b) ^ (pm == 2), 4);
      push(1'b1, 4*sb);
      if (k == 0) push(1'b1, gap);
    end
  endtask

  task automatic frame(input int u, input int len, input string tag, input int sp0, input logic v0,
                       input int sp1, input logic v1, input bit hold);
    st[u] = 1'b1;
    tick();
    st[u] = 1'b0;
    chk({tag, "_busy"}, 32'(bsy[u]), 1);
    for (int c = 0; c < len; c++) begin
      if (c == 10) st[u] = 1'b1;
      if (c == 11) st[u] = 1'b0;
      if (hold && c == len-1) st[u] = 1'b1;
      chk($sformatf("%s_c%0d", tag, c), 32'(bo[u]), 32'(c < exp_q.size() ? exp_q[c] : 1'b1));
      if (c == sp0) chk({tag, "_spot0"}, 32'(bo[u]), 32'(v0));
      if (c == sp1) chk({tag, "_spot1"}, 32'(bo[u]), 32'(v1));
      if (c == len-1) chk({tag, "_done_early"}, 32'(dn[u]), 0);
      tick();
    end
    chk({tag, "_done"}, 32'(dn[u]), 1);
    chk({tag, "_busy_end"}, 32'(bsy[u]), 0);
    chk({tag, "_bc"}, 32'(bc[u]), 2);
    chk({tag, "_line_end"}, 32'(bo[u]), 1);
    if (!hold) begin
      tick();
      chk({tag, "_done_once"}, 32'(dn[u]), 0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin st[u] = 1'b0; ab[u] = 1'b0; end
    in_data = 16'hA53C;
    l028 = 20'b0101001011_0001111001;
    repeat (2) tick();
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("rst_bo%0d", u), 32'(bo[u]), 1);
      chk($sformatf("rst_busy%0d", u), 32'(bsy[u]), 0);
      chk($sformatf("rst_done%0d", u), 32'(dn[u]), 0);
      chk($sformatf("rst_bc%0d", u), 32'(bc[u]), 0);
    end
    rst_n = 1'b1;
    tick();
    load_hand(l028);
    frame(0, 80, "r028", -1, 1'b0, -1, 1'b0, 1'b1);
    tick();
    st[0] = 1'b0;
    chk("restart_busy", 32'(bsy[0]), 1);
    chk("restart_bo", 32'(bo[0]), 0);
    chk("restart_bc", 32'(bc[0]), 0);
    repeat (50) tick();
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk("abort_bo", 32'(bo[0]), 1);
    chk("abort_busy", 32'(bsy[0]), 0);
    chk("abort_done", 32'(dn[0]), 0);
    chk("abort_bc", 32'(bc[0]), 1);
    repeat (3) begin
      tick();
      chk("abort_nodone", 32'(dn[0]), 0);
      chk("abort_idle_bo", 32'(bo[0]), 1);
    end
    st[0] = 1'b1;
    ab[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    ab[0] = 1'b0;
    chk("stab_busy", 32'(bsy[0]), 0);
    chk("stab_bo", 32'(bo[0]), 1);
    chk("stab_bc", 32'(bc[0]), 1);
    tick();
    frame(0, 80, "r031", -1, 1'b0, -1, 1'b0, 1'b0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (50) tick();
    chk("pre_rst_bc", 32'(bc[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bo", 32'(bo[0]), 1);
    chk("arst_busy", 32'(bsy[0]), 0);
    chk("arst_bc", 32'(bc[0]), 0);
    chk("arst_done", 32'(dn[0]), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bsy[0]), 0);
    frame(0, 80, "post_rst", -1, 1'b0, -1, 1'b0, 1'b0);
    in_data = 16'h0700;
    build(16'h0700, 1, 1, 0);
    frame(1, 88, "r029e", 37, 1'b1, 81, 1'b0, 1'b0);
    build(16'h0700, 2, 1, 0);
    frame(2, 88, "r029o", 37, 1'b0, 81, 1'b1, 1'b0);
    in_data = 16'hA53C;
    build(16'hA53C, 1, 2, 3);
    frame(3, 99, "r030", 50, 1'b1, 51, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
